// File: rtl/c4_move_controller_if.sv
// Player, board-write and win-checker signals around the Connect-4 move controller.
// The controller takes the master modport; the board, checker and player side take slave.
interface c4_move_controller_if;
  logic       go;
  logic       new_game;
  logic [2:0] col_sel;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic [1:0] wr_piece;
  logic       board_clr;
  logic       chk_start;
  logic       chk_done;
  logic [1:0] chk_winner;
  logic [1:0] turn;
  logic [1:0] winner;
  logic       draw;
  logic       game_over;
  logic       busy;
  logic       illegal;

  modport master (
    input  go, new_game, col_sel, chk_done, chk_winner,
    output wr_en, wr_col, wr_row, wr_piece, board_clr, chk_start,
           turn, winner, draw, game_over, busy, illegal
  );

  modport slave (
    output go, new_game, col_sel, chk_done, chk_winner,
    input  wr_en, wr_col, wr_row, wr_piece, board_clr, chk_start,
           turn, winner, draw, game_over, busy, illegal
  );
endinterface

// File: rtl/c4_move_controller.sv
// Connect-4 move sequencer: validates a drop, writes the lowest free cell, runs the win-check
// handshake and tracks turn / winner / draw. Sole owner of column heights and the move count.
module c4_move_controller #(
  parameter int unsigned COLS        = 7,
  parameter int unsigned ROWS        = 6,
  parameter int unsigned CHK_TIMEOUT = 255
) (
  input logic                  CLOCK_50,
  input logic                  resetn,
  c4_move_controller_if.master bus
);
  localparam int unsigned HeightW = $clog2(ROWS + 1);
  localparam int unsigned CntW    = $clog2(COLS * ROWS + 1);
  localparam int unsigned TmoW    = $clog2(CHK_TIMEOUT + 1);
  localparam int unsigned IdxW    = $clog2(COLS);

  typedef enum logic [2:0] {
    StIdle, StValidate, StWrite, StChkReq, StChkWait, StNext, StGameOver, StClear
  } state_e;

  state_e state_q, state_d;

  logic                          go_q, new_game_q;
  logic [2:0]                    col_q, col_d;
  logic [COLS-1:0][HeightW-1:0]  height_q, height_d;
  logic [CntW-1:0]               move_cnt_q, move_cnt_d;
  logic [TmoW-1:0]               tmo_q, tmo_d;
  logic [1:0]                    turn_q, turn_d;
  logic [1:0]                    winner_q, winner_d;
  logic                          draw_q, draw_d;
  logic                          wr_en_q, wr_en_d;
  logic [2:0]                    wr_col_q, wr_col_d;
  logic [2:0]                    wr_row_q, wr_row_d;
  logic [1:0]                    wr_piece_q, wr_piece_d;
  logic                          board_clr_q, board_clr_d;
  logic                          chk_start_q, chk_start_d;
  logic                          illegal_q, illegal_d;

  logic                          go_rise, ng_rise;
  logic [HeightW-1:0]            cur_height;
  logic                          col_legal;
  logic                          board_full;
  logic                          chk_fire;
  logic [1:0]                    chk_win;

  assign go_rise    = bus.go & ~go_q;
  assign ng_rise    = bus.new_game & ~new_game_q;
  assign board_full = (move_cnt_q == CntW'(COLS * ROWS));
  // A timeout behaves exactly like chk_done reporting "no winner".
  assign chk_fire   = bus.chk_done | (tmo_q == TmoW'(CHK_TIMEOUT - 1));
  assign chk_win    = bus.chk_done ? bus.chk_winner : 2'b00;

  always_comb begin
    cur_height = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (32'(col_q) == i) cur_height = height_q[IdxW'(i)];
    end
  end

  assign col_legal = (32'(col_q) < COLS) && (cur_height != HeightW'(ROWS));

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (go_rise) state_d = StValidate;
      StValidate: state_d = col_legal ? StWrite : StIdle;
      StWrite:    state_d = StChkReq;
      StChkReq:   state_d = StChkWait;
      StChkWait: begin
        if (chk_fire) state_d = (chk_win != 2'b00 || board_full) ? StGameOver : StNext;
      end
      StNext:     state_d = StIdle;
      StGameOver: if (ng_rise) state_d = StClear;
      StClear:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    col_d       = col_q;
    height_d    = height_q;
    move_cnt_d  = move_cnt_q;
    tmo_d       = tmo_q;
    turn_d      = turn_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    wr_en_d     = 1'b0;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    wr_piece_d  = wr_piece_q;
    board_clr_d = 1'b0;
    chk_start_d = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      StIdle:     if (go_rise) col_d = bus.col_sel;
      StValidate: if (!col_legal) illegal_d = 1'b1;
      StWrite: begin
        wr_en_d    = 1'b1;
        wr_col_d   = col_q;
        wr_row_d   = 3'(cur_height);
        wr_piece_d = turn_q;
        for (int unsigned i = 0; i < COLS; i++) begin
          if (32'(col_q) == i && height_q[IdxW'(i)] < HeightW'(ROWS)) begin
            height_d[IdxW'(i)] = height_q[IdxW'(i)] + 1'b1;
          end
        end
        move_cnt_d = move_cnt_q + 1'b1;
      end
      StChkReq: begin
        chk_start_d = 1'b1;
        tmo_d       = '0;
      end
      StChkWait: begin
        tmo_d = tmo_q + 1'b1;
        if (chk_fire) begin
          // A win on the last move beats a draw.
          if (chk_win != 2'b00) winner_d = chk_win;
          else if (board_full)  draw_d   = 1'b1;
        end
      end
      StNext: turn_d = (turn_q == 2'b01) ? 2'b10 : 2'b01;
      StClear: begin
        board_clr_d = 1'b1;
        height_d    = '0;
        move_cnt_d  = '0;
        winner_d    = 2'b00;
        draw_d      = 1'b0;
        turn_d      = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      go_q        <= 1'b0;
      new_game_q  <= 1'b0;
      col_q       <= '0;
      height_q    <= '0;
      move_cnt_q  <= '0;
      tmo_q       <= '0;
      turn_q      <= 2'b01;
      winner_q    <= 2'b00;
      draw_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_piece_q  <= '0;
      board_clr_q <= 1'b0;
      chk_start_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      go_q        <= bus.go;
      new_game_q  <= bus.new_game;
      col_q       <= col_d;
      height_q    <= height_d;
      move_cnt_q  <= move_cnt_d;
      tmo_q       <= tmo_d;
      turn_q      <= turn_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
      wr_en_q     <= wr_en_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_piece_q  <= wr_piece_d;
      board_clr_q <= board_clr_d;
      chk_start_q <= chk_start_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_col    = wr_col_q;
  assign bus.wr_row    = wr_row_q;
  assign bus.wr_piece  = wr_piece_q;
  assign bus.board_clr = board_clr_q;
  assign bus.chk_start = chk_start_q;
  assign bus.turn      = turn_q;
  assign bus.winner    = winner_q;
  assign bus.draw      = draw_q;
  assign bus.game_over = (winner_q != 2'b00) | draw_q;
  assign bus.busy      = (state_q != StIdle) && (state_q != StGameOver);
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_c4_move_controller.sv
// Self-checking bench for c4_move_controller: directed scenarios plus random play,
// compared against a board-level model of heights, turn and game result.
module tb_c4_move_controller;
  localparam int Timeout = 255;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  c4_move_controller_if bus ();

  c4_move_controller #(
    .COLS        (7),
    .ROWS        (6),
    .CHK_TIMEOUT (Timeout)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the game
  int         h[7];
  int         cnt;
  logic [1:0] m_turn, m_winner;
  logic       m_draw;
  logic [11:0] exp_mv, got_mv;

  int         obs_wr, obs_ill, obs_wr_k, obs_chk_k, obs_end_k, obs_clr;
  logic [2:0] obs_col, obs_row;
  logic [1:0] obs_piece;

  localparam logic [10:0] ResetVals = 11'b01_00_0_0_0_0000;

  task automatic model_reset();
    for (int i = 0; i < 7; i++) h[i] = 0;
    cnt = 0; m_turn = 2'b01; m_winner = 2'b00; m_draw = 1'b0;
  endtask

  // Expected {wr count, illegal count, col, row, piece} for one go press.
  task automatic model_move(input int col, input logic [1:0] ret);
    exp_mv = '0;
    if (m_winner != 2'b00 || m_draw) return;
    if (col >= 7 || h[col] == 6) begin
      exp_mv = {2'd0, 2'd1, 8'd0};
      return;
    end
    exp_mv = {2'd1, 2'd0, 3'(col), 3'(h[col]), m_turn};
    h[col]++;
    cnt++;
    if (ret != 2'b00)  m_winner = ret;
    else if (cnt == 42) m_draw = 1'b1;
    else               m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
  endtask

  function automatic logic [6:0] exp_status();
    return {m_turn, m_winner, m_draw, (m_winner != 2'b00) || m_draw, 1'b0};
  endfunction

  function automatic logic [6:0] dut_status();
    return {bus.turn, bus.winner, bus.draw, bus.game_over, bus.busy};
  endfunction

  function automatic logic [10:0] dut_all();
    return {dut_status(), bus.wr_en, bus.board_clr, bus.chk_start, bus.illegal};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0; bus.go = 1'b0; bus.new_game = 1'b0; bus.col_sel = '0;
    bus.chk_done = 1'b0; bus.chk_winner = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // One go press; answers chk_start after dly cycles (dly<0: never). k counts edges after
  // the edge that samples the go rise.
  task automatic do_move(input int col, input logic [1:0] ret, input int dly);
    bit sent;
    bit fin;
    sent = 0; fin = 0;
    obs_wr = 0; obs_ill = 0; obs_wr_k = -1; obs_chk_k = -1; obs_end_k = -1;
    obs_col = '0; obs_row = '0; obs_piece = '0;
    @(negedge clk);
    bus.go = 1'b1; bus.col_sel = 3'(col);
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      bus.go = 1'b0; bus.chk_done = 1'b0; bus.chk_winner = 2'b00;
      if (bus.wr_en) begin
        obs_wr++; obs_wr_k = k;
        obs_col = bus.wr_col; obs_row = bus.wr_row; obs_piece = bus.wr_piece;
      end
      if (bus.illegal) obs_ill++;
      if (bus.chk_start) obs_chk_k = k;
      if (dly >= 0 && !sent && obs_chk_k >= 0 && k == obs_chk_k + dly) begin
        bus.chk_done = 1'b1; bus.chk_winner = ret; sent = 1;
      end else if (k >= 1 && !bus.busy) begin
        fin = 1; obs_end_k = k;
      end
    end
    bus.chk_done = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL move_done col=%0d: busy=%b after 400 cycles, required 0", col, bus.busy);
    end
    got_mv = {2'(obs_wr), 2'(obs_ill), obs_col, obs_row, obs_piece};
  endtask

  task automatic pulse_new_game();
    obs_clr = 0;
    @(negedge clk);
    bus.new_game = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.new_game = 1'b0;
      if (bus.board_clr) obs_clr++;
    end
    bus.new_game = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (dut_all() !== ResetVals) begin
      errors++; $display("FAIL reset_state: got %b required %b", dut_all(), ResetVals);
    end
  endtask

  task automatic test_first_move();
    apply_reset();
    model_move(3, 2'b00);
    do_move(3, 2'b00, 0);
    checks++;
    if (got_mv !== exp_mv) begin
      errors++; $display("FAIL first_move: got %h required %h", got_mv, exp_mv);
    end
    checks++;
    if (obs_wr_k !== 2 || obs_chk_k !== 3) begin
      errors++;
      $display("FAIL first_latency: got wr@%0d chk@%0d required wr@2 chk@3", obs_wr_k, obs_chk_k);
    end
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL first_status: got %b required %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_column_full();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      model_move(0, 2'b00);
      do_move(0, 2'b00, int'($urandom_range(0, 4)));
      checks++;
      if (got_mv !== exp_mv) begin
        errors++; $display("FAIL col_full move %0d: got %h required %h", i, got_mv, exp_mv);
      end
      checks++;
      if (dut_status() !== exp_status()) begin
        errors++;
        $display("FAIL col_full status %0d: got %b required %b", i, dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_illegal_and_hold();
    bit sent;
    apply_reset();
    model_move(7, 2'b00);
    do_move(7, 2'b00, 0);
    checks++;
    if (got_mv !== exp_mv) begin
      errors++; $display("FAIL bad_col: got %h required %h", got_mv, exp_mv);
    end
    // chk_done while idle must not load a winner
    @(negedge clk); bus.chk_done = 1'b1; bus.chk_winner = 2'b01;
    @(negedge clk); bus.chk_done = 1'b0; bus.chk_winner = 2'b00;
    @(negedge clk);
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL stray_done: got %b required %b", dut_status(), exp_status());
    end
    obs_wr = 0; obs_ill = 0; sent = 0;
    @(negedge clk); bus.go = 1'b1; bus.col_sel = 3'd5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.chk_done = 1'b0;
      if (bus.wr_en) obs_wr++;
      if (bus.illegal) obs_ill++;
      if (bus.chk_start && !sent) begin bus.chk_done = 1'b1; bus.chk_winner = 2'b00; sent = 1; end
    end
    bus.go = 1'b0; bus.chk_done = 1'b0;
    repeat (3) @(negedge clk);
    model_move(5, 2'b00);
    checks++;
    if (obs_wr !== 1 || obs_ill !== 0) begin
      errors++; $display("FAIL held_go: got wr=%0d ill=%0d required wr=1 ill=0", obs_wr, obs_ill);
    end
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL held_status: got %b required %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_win();
    int cols[7];
    cols = '{0, 6, 1, 6, 2, 6, 3};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      model_move(cols[i], (i == 6) ? 2'b01 : 2'b00);
      do_move(cols[i], (i == 6) ? 2'b01 : 2'b00, 1);
      checks++;
      if (got_mv !== exp_mv) begin
        errors++; $display("FAIL win move %0d: got %h required %h", i, got_mv, exp_mv);
      end
    end
    checks++;
    if (dut_status() !== exp_status()) begin
      errors++; $display("FAIL win_status: got %b required %b", dut_status(), exp_status());
    end
    model_move(4, 2'b00);
    do_move(4, 2'b00, 0);
    checks++;
    if (got_mv !== exp_mv || dut_status() !== exp_status()) begin
      errors++;
      $display("FAIL go_in_game_over: got %h/%b required %h/%b",
               got_mv, dut_status(), exp_mv, exp_status());
    end
    pulse_new_game();
    model_reset();
    checks++;
    if (obs_clr !== 1 || dut_status() !== exp_status()) begin
      errors++;
      $display("FAIL new_game: got clr=%0d st=%b required clr=1 st=%b",
               obs_clr, dut_status(), exp_status());
    end
    model_move(0, 2'b00);
    do_move(0, 2'b00, 0);
    checks++;
    if (got_mv !== exp_mv) begin
      errors++; $display("FAIL after_clear: got %h required %h", got_mv, exp_mv);
    end
  endtask

  task automatic test_fill_board(input logic [1:0] last_ret);
    logic [1:0] r;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      for (int row = 0; row < 6; row++) begin
        r = (c * 6 + row + 1 == 42) ? last_ret : 2'b00;
        model_move(c, r);
        do_move(c, r, int'($urandom_range(0, 3)));
        checks++;
        if (got_mv !== exp_mv || dut_status() !== exp_status()) begin
          errors++;
          $display("FAIL fill c%0d r%0d: got %h/%b required %h/%b",
                   c, row, got_mv, dut_status(), exp_mv, exp_status());
        end
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    model_move(1, 2'b00);
    do_move(1, 2'b00, -1);
    checks++;
    if (got_mv !== exp_mv || dut_status() !== exp_status()) begin
      errors++;
      $display("FAIL timeout_move: got %h/%b required %h/%b",
               got_mv, dut_status(), exp_mv, exp_status());
    end
    checks++;
    if (obs_end_k < 3 + Timeout || obs_end_k > 5 + Timeout) begin
      errors++;
      $display("FAIL timeout_len: got idle at %0d required %0d..%0d",
               obs_end_k, 3 + Timeout, 5 + Timeout);
    end
  endtask

  task automatic test_reset_mid_check();
    bit seen;
    apply_reset();
    seen = 0;
    @(negedge clk); bus.go = 1'b1; bus.col_sel = 3'd2;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (bus.chk_start) seen = 1;
    end
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || dut_all() !== ResetVals) begin
      errors++;
      $display("FAIL reset_mid_check: got seen=%0d %b required seen=1 %b", seen, dut_all(),
               ResetVals);
    end
    resetn = 1'b1;
    model_reset();
    model_move(2, 2'b00);
    do_move(2, 2'b00, 1);
    checks++;
    if (got_mv !== exp_mv) begin
      errors++; $display("FAIL post_reset_move: got %h required %h", got_mv, exp_mv);
    end
  endtask

  task automatic test_random();
    int         col;
    int         dly;
    logic [1:0] r;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      col = int'($urandom_range(0, 7));
      dly = int'($urandom_range(0, 6));
      r   = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      if ((m_winner != 2'b00 || m_draw) && $urandom_range(0, 1) == 1) begin
        pulse_new_game();
        model_reset();
      end
      model_move(col, r);
      do_move(col, r, dly);
      checks++;
      if (got_mv !== exp_mv || dut_status() !== exp_status()) begin
        errors++;
        $display("FAIL random %0d col%0d: got %h/%b required %h/%b",
                 i, col, got_mv, dut_status(), exp_mv, exp_status());
      end
    end
  endtask

  initial begin
    resetn = 1'b0; bus.go = 1'b0; bus.new_game = 1'b0; bus.col_sel = '0;
    bus.chk_done = 1'b0; bus.chk_winner = '0;
    model_reset();
    test_reset();
    test_first_move();
    test_column_full();
    test_illegal_and_hold();
    test_win();
    test_fill_board(2'b00);
    test_fill_board(2'b10);
    test_timeout();
    test_reset_mid_check();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
